// File: rtl/network_ctrl.sv
// Command sequencer ahead of the network reset stage: turns host commands into
// shaped net_clear pulses and net_en run windows, returning one response per command.
module network_ctrl #(
  parameter int RUN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [RUN_WIDTH-1:0] cmd_arg,
  output logic                 net_clear,
  output logic                 net_en,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_op,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_CLR     = 2'd1;
  localparam logic [1:0] OP_RUN     = 2'd2;
  localparam logic [1:0] OP_CLR_RUN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GAP,
    S_RUN,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [RUN_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 net_clear_q, net_clear_d;
  logic                 net_en_q, net_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_op_q, rsp_op_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    cycle_count_d = cycle_count_q;

    if (net_en_q && (cycle_count_q != {CNT_WIDTH{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          cnt_d = cmd_arg;
          case (cmd_op)
            OP_NOP:     state_d = S_RESP;
            OP_CLR:     state_d = S_CLEAR;
            OP_CLR_RUN: state_d = S_CLEAR;
            default:    state_d = (cmd_arg != '0) ? S_RUN : S_RESP;
          endcase
        end
      end
      S_CLEAR: begin
        cycle_count_d = '0;
        state_d       = S_GAP;
      end
      S_GAP: begin
        state_d = ((op_q == OP_CLR_RUN) && (cnt_q != '0)) ? S_RUN : S_RESP;
      end
      S_RUN: begin
        // cnt_q holds the run cycles remaining, including the current one
        if (cnt_q == RUN_WIDTH'(1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - RUN_WIDTH'(1);
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    cmd_ready_d = (state_d == S_IDLE);
    net_clear_d = (state_d == S_CLEAR);
    net_en_d    = (state_d == S_RUN);
    rsp_valid_d = (state_d == S_RESP);
    rsp_op_d    = (state_d == S_RESP) ? op_d : rsp_op_q;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      cnt_q         <= '0;
      cycle_count_q <= '0;
      cmd_ready_q   <= 1'b0;
      net_clear_q   <= 1'b0;
      net_en_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      cycle_count_q <= cycle_count_d;
      cmd_ready_q   <= cmd_ready_d;
      net_clear_q   <= net_clear_d;
      net_en_q      <= net_en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_op_q      <= rsp_op_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign net_clear   = net_clear_q;
  assign net_en      = net_en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_network_ctrl.sv
// Directed bench for network_ctrl; a second instance with a 4-bit counter
// shares the command inputs to exercise saturation.
module tb_network_ctrl;

  logic        clk;
  logic        arstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        net_clear;
  logic        net_en;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] cycle_count;

  logic        cmd_ready4;
  logic        net_clear4;
  logic        net_en4;
  logic        rsp_valid4;
  logic [1:0]  rsp_op4;
  logic [3:0]  cycle_count4;

  int checks;
  int failures;
  int en_cycles;
  int waited;

  network_ctrl #(.RUN_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .arstn(arstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .net_clear(net_clear), .net_en(net_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .cycle_count(cycle_count)
  );

  network_ctrl #(.RUN_WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .arstn(arstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .net_clear(net_clear4), .net_en(net_en4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_op(rsp_op4),
    .cycle_count(cycle_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns sampled in cycle 1 after the accept edge
  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_arg   = 16'h0;
  endtask

  // Counts net_en cycles until rsp_valid, checking clear/en exclusivity
  task automatic wait_rsp(input int budget);
    en_cycles = 0;
    waited    = 0;
    while (rsp_valid !== 1'b1 && waited < budget) begin
      if (net_en === 1'b1) en_cycles++;
      if (net_en === 1'b1 && net_clear === 1'b1) chk("clr_en_overlap", 32'd1, 32'd0);
      tick();
      waited++;
    end
    chk("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_low", {31'd0, rsp_valid}, 32'd0);
    chk("hs_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    arstn     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 16'h0;
    rsp_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_net_clear", {31'd0, net_clear}, 32'd0);
    chk("rst_net_en", {31'd0, net_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_op", {30'd0, rsp_op}, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    #19 arstn = 1'b1;
    tick();
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // CLR with garbage arg: clear at +1, gap at +2, response at +3
    issue(2'd1, 16'hFFFF);
    chk("clr_c1_clear", {31'd0, net_clear}, 32'd1);
    chk("clr_c1_en", {31'd0, net_en}, 32'd0);
    chk("clr_c1_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("clr_c2_clear", {31'd0, net_clear}, 32'd0);
    chk("clr_c2_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("clr_c3_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("clr_c3_op", {30'd0, rsp_op}, 32'd1);
    chk("clr_c3_count", cycle_count, 32'd0);
    handshake();

    // RUN 5 then RUN 3
    issue(2'd2, 16'd5);
    for (int i = 1; i <= 5; i++) begin
      chk("run5_en", {31'd0, net_en}, 32'd1);
      chk("run5_clear", {31'd0, net_clear}, 32'd0);
      tick();
    end
    chk("run5_en_off", {31'd0, net_en}, 32'd0);
    chk("run5_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("run5_op", {30'd0, rsp_op}, 32'd2);
    chk("run5_count", cycle_count, 32'd5);
    handshake();
    issue(2'd2, 16'd3);
    tick();
    tick();
    tick();
    chk("run3_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("run3_count", cycle_count, 32'd8);
    handshake();

    // CLR_RUN 4 with response stalled
    issue(2'd3, 16'd4);
    chk("cr_c1_clear", {31'd0, net_clear}, 32'd1);
    chk("cr_c1_en", {31'd0, net_en}, 32'd0);
    tick();
    chk("cr_c2_clear", {31'd0, net_clear}, 32'd0);
    chk("cr_c2_en", {31'd0, net_en}, 32'd0);
    tick();
    for (int i = 3; i <= 6; i++) begin
      chk("cr_en", {31'd0, net_en}, 32'd1);
      chk("cr_clear", {31'd0, net_clear}, 32'd0);
      tick();
    end
    chk("cr_c7_en", {31'd0, net_en}, 32'd0);
    chk("cr_c7_count", cycle_count, 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("cr_hold_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("cr_hold_op", {30'd0, rsp_op}, 32'd3);
      chk("cr_hold_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    handshake();

    // RUN 0 and NOP with rsp_ready held high
    rsp_ready = 1'b1;
    issue(2'd2, 16'd0);
    chk("run0_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("run0_op", {30'd0, rsp_op}, 32'd2);
    chk("run0_en", {31'd0, net_en}, 32'd0);
    tick();
    chk("run0_done", {31'd0, rsp_valid}, 32'd0);
    chk("run0_ready", {31'd0, cmd_ready}, 32'd1);
    issue(2'd0, 16'h1234);
    chk("nop_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("nop_op", {30'd0, rsp_op}, 32'd0);
    chk("nop_en", {31'd0, net_en}, 32'd0);
    chk("nop_clear", {31'd0, net_clear}, 32'd0);
    tick();

    // CLRs back to back: pulses at cycles 1 and 5, responses at 3 and 7
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("b2b_clear", {31'd0, net_clear}, {31'd0, (i % 4) == 1});
      chk("b2b_rsp", {31'd0, rsp_valid}, {31'd0, (i % 4) == 3});
      if (i < 8) tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();

    // Saturation on the 4-bit instance and maximum run length
    issue(2'd1, 16'd0);
    wait_rsp(10);
    handshake();
    chk("sat_clr_count4", {28'd0, cycle_count4}, 32'd0);
    issue(2'd2, 16'd20);
    wait_rsp(30);
    chk("sat_en_cycles", en_cycles, 32'd20);
    chk("sat_count32", cycle_count, 32'd20);
    chk("sat_count4", {28'd0, cycle_count4}, 32'd15);
    handshake();
    issue(2'd2, 16'hFFFF);
    wait_rsp(70000);
    chk("max_en_cycles", en_cycles, 32'd65535);
    chk("max_count32", cycle_count, 32'd65555);
    chk("max_count4", {28'd0, cycle_count4}, 32'd15);
    handshake();
    issue(2'd1, 16'd0);
    wait_rsp(10);
    chk("sat_reclr_count32", cycle_count, 32'd0);
    chk("sat_reclr_count4", {28'd0, cycle_count4}, 32'd0);
    handshake();

    // Reset in the middle of RUN 100
    issue(2'd2, 16'd100);
    for (int i = 1; i < 50; i++) tick();
    chk("mid_en_before", {31'd0, net_en}, 32'd1);
    chk("mid_count_before", cycle_count, 32'd49);
    #2 arstn = 1'b0;
    #1;
    chk("mid_en_async", {31'd0, net_en}, 32'd0);
    chk("mid_count_async", cycle_count, 32'd0);
    chk("mid_ready_async", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #3 arstn = 1'b1;
    tick();
    chk("mid_ready_after", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_no_en", {31'd0, net_en}, 32'd0);
      tick();
    end
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
